imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate generator for the RV32/RV64 decode path. It extracts and extends the immediate for every base RISC-V format (I, S, B, U, J) plus the CSR zimm and shift-amount forms. A single registered stage drives the output, behind a valid/ready handshake with a two-entry skid buffer, so decode can stall without losing instructions. A sideband tag travels with each instruction, and an illegal-format flag is raised for the reserved encoding.

Parameters:
XLEN, 32, output immediate width; legal values are 32 or 64 (elaboration error otherwise).
TAG_W, 4, width of the sideband tag carried alongside each instruction (must be ≥1).
CNT_W, 16, width of the accepted-instruction counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream has an instruction.
in_ready  output  1  block can accept; transfer when in_valid && in_ready.
in_ins  input  32  full instruction word.
in_imm_src  input  3  format select (encoding below).
in_tag  input  TAG_W  sideband, returned unchanged.
out_valid  output  1  out_imm/out_tag/out_illegal are valid.
out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
out_imm  output  XLEN  extended immediate.
out_tag  output  TAG_W  tag of the presented entry.
out_illegal  output  1  entry used the reserved format.
acc_cnt  output  CNT_W  count of accepted input transfers.

Behaviour:
- Format encoding and result (s = ins[31] replicated to XLEN):
  - 0 I: s, ins[31:20].
  - 1 S: s, ins[31:25], ins[11:7].
  - 2 B: s, ins[31], ins[7], ins[30:25], ins[11:8], 0.
  - 3 U: s above bit 31, ins[31:12], twelve zeros (bits 63:32 sign-filled when XLEN=64).
  - 4 J: s, ins[31], ins[19:12], ins[20], ins[30:21], 0.
  - 5 Z: ins[19:15] zero-extended.
  - 6 SH: ins[24:20] zero-extended when XLEN=32, ins[25:20] when XLEN=64.
  - 7: imm = 0, illegal = 1.
- Illegal is 0 for codes 0–6.
- Extension is combinational on input. The result, tag and illegal flag are captured on acceptance.
- Latency: 1 cycle from accepted input to out_valid, when the buffer is empty.
- Storage: main register (presented on the outputs) plus a skid register. Occupancy FSM has states EMPTY, ONE, TWO.
  - EMPTY: accept → ONE.
  - ONE:
    - accept with no drain → TWO (entry goes to skid).
    - drain with no accept → EMPTY.
    - accept and drain in the same cycle → ONE (new entry goes to main).
  - TWO: drain → ONE (skid moves to main). No accept is possible.
- in_ready = (state != TWO), derived from registered state only. No combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY).
- Outputs hold stable while out_valid && !out_ready. Order is strictly FIFO.
- acc_cnt increments by 1 on every input transfer and wraps modulo 2^CNT_W with no saturation.
- Reset, asynchronous, any time including mid-transfer:
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - out_imm = 0, out_tag = 0, out_illegal = 0, acc_cnt = 0.
  - Skid contents are cleared and buffered entries are discarded.
  - No transfer is recorded on a cycle where rst is high.
- X on in_ins or in_imm_src while in_valid is low must not propagate to the outputs.

Decomposition:
- Shared package imm_pkg:
  - imm_src_e enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH, IMM_RSV).
  - Constant INS_W = 32.
  - Entry struct {imm, tag, illegal}.
- One combinational sub-module, imm_extend_core (XLEN parameter; in ins, imm_src; out imm, illegal). It replaces the old single-format extender and is reusable elsewhere in decode.
- The pipe wrapper owns the FSM, registers and counter.

Test Plan:
- XLEN=32, I, 0xFFF00093, then S, 0xFE112E23 back-to-back with out_ready=1 → 0xFFFFFFFF then 0xFFFFFFFC, one cycle apart, tags preserved; acc_cnt = 2.
- B, 0xFE000CE3 → 0xFFFFFFF8.
- U, 0x123450B7 → 0x12345000.
- J, 0x0010006F → 0x00000800.
- Z, 0x0002D073 → 0x00000005 (ins[19:15] = 5).
- Code 7 → imm 0, illegal 1.
- XLEN=64:
  - I 0xFFF00093 → 0xFFFFFFFF_FFFFFFFF.
  - SH with ins[25:20] = 0x3F → 0x3F.
  - U 0x800000B7 → 0xFFFFFFFF_80000000.
- Backpressure: hold out_ready=0 and offer tags 1, 2, 3.
  - Tags 1 and 2 are accepted; in_ready drops after the second.
  - Tag 3 is held and out_imm stays stable.
  - Raise out_ready → tags delivered in order 1, 2, 3, with in_ready returning high the cycle after the first drain.
- Simultaneous accept and drain in ONE for 10 consecutive cycles → one result per cycle, in_ready constantly 1.
- Reset mid-operation: assert rst asynchronously (between clock edges) while in TWO → out_valid falls immediately, in_ready = 1, acc_cnt = 0. Buffered entries are never emitted after release.
- Counter wrap with CNT_W = 4: perform 17 transfers → acc_cnt = 1.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the immediate-extension path: format select, occupancy
// states of the output pipe, and the fixed instruction width.
package imm_pkg;

  localparam int INS_W = 32;

  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_B   = 3'd2,
    IMM_U   = 3'd3,
    IMM_J   = 3'd4,
    IMM_Z   = 3'd5,
    IMM_SH  = 3'd6,
    IMM_RSV = 3'd7
  } imm_src_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational RISC-V immediate extractor for every base format plus the
// CSR zimm and shift-amount forms; XLEN selects 32- or 64-bit results.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INS_W-1:0] ins,
  input  imm_src_e         imm_src,
  output logic [XLEN-1:0]  imm,
  output logic             illegal
);

  // The opcode field never contributes to an immediate.
  logic unused_opcode_s;
  assign unused_opcode_s = ^ins[6:0];

  // Field gather per format; signed casts provide the sign fill to XLEN.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:   imm = XLEN'($signed(ins[31:20]));
      IMM_S:   imm = XLEN'($signed({ins[31:25], ins[11:7]}));
      IMM_B:   imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      IMM_U:   imm = XLEN'($signed({ins[31:12], 12'h000}));
      IMM_J:   imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      IMM_Z:   imm = XLEN'(ins[19:15]);
      IMM_SH:  imm = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
      IMM_RSV: begin
        imm     = '0;
        illegal = 1'b1;
      end
      default: begin
        imm     = '0;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with a valid/ready handshake and a
// two-entry (main + skid) buffer; also counts accepted instructions.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] in_ins,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] acc_cnt
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("imm_extend_pipe: TAG_W must be at least 1");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  occ_e             state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  ext_imm_s;
  logic             ext_illegal_s;
  logic             accept_s;
  logic             drain_s;
  entry_t           new_s;

  imm_extend_core #(.XLEN(XLEN)) u_core (
    .ins     (in_ins),
    .imm_src (imm_src_e'(in_imm_src)),
    .imm     (ext_imm_s),
    .illegal (ext_illegal_s)
  );

  // Handshake flags come only from registered state, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state_q != OCC_TWO);
  assign out_valid = (state_q != OCC_EMPTY);
  assign accept_s  = in_valid & in_ready;
  assign drain_s   = out_valid & out_ready;
  assign new_s     = '{imm: ext_imm_s, tag: in_tag, illegal: ext_illegal_s};

  // Occupancy transitions and data movement between main and skid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q + CNT_W'(accept_s);
    case (state_q)
      OCC_EMPTY: begin
        if (accept_s) begin
          main_d  = new_s;
          state_d = OCC_ONE;
        end else begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (accept_s && drain_s) begin
          main_d = new_s;
        end else if (accept_s) begin
          skid_d  = new_s;
          state_d = OCC_TWO;
        end else if (drain_s) begin
          state_d = OCC_EMPTY;
        end else begin
          state_d = OCC_ONE;
        end
      end
      OCC_TWO: begin
        if (drain_s) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = OCC_ONE;
        end else begin
          state_d = OCC_TWO;
        end
      end
      default: begin
        state_d = OCC_EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
  end

  // State, storage and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_imm     = main_q.imm;
  assign out_tag     = main_q.tag;
  assign out_illegal = main_q.illegal;
  assign acc_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: three instances (XLEN=32, XLEN=64,
// and a 4-bit counter variant) share one input stream.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_ins;
  logic [2:0]  in_imm_src;
  logic [3:0]  in_tag;

  logic        rdy_a, ov_a, ill_a;
  logic [31:0] imm_a;
  logic [3:0]  tag_a;
  logic [15:0] cnt_a;

  logic        rdy_b, ov_b, ill_b;
  logic [63:0] imm_b;
  logic [3:0]  tag_b;
  logic [15:0] cnt_b;

  logic        rdy_c, ov_c, ill_c;
  logic [31:0] imm_c;
  logic [3:0]  tag_c;
  logic [3:0]  cnt_c;

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [3:0]  tag;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   sent   = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_ins(in_ins),
    .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov_a), .out_ready(out_ready),
    .out_imm(imm_a), .out_tag(tag_a), .out_illegal(ill_a), .acc_cnt(cnt_a));

  imm_extend_pipe #(.XLEN(64), .TAG_W(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_ins(in_ins),
    .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov_b), .out_ready(out_ready),
    .out_imm(imm_b), .out_tag(tag_b), .out_illegal(ill_b), .acc_cnt(cnt_b));

  imm_extend_pipe #(.XLEN(32), .TAG_W(4), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .in_ins(in_ins),
    .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov_c), .out_ready(out_ready),
    .out_imm(imm_c), .out_tag(tag_c), .out_illegal(ill_c), .acc_cnt(cnt_c));

  function automatic logic [63:0] model(input logic [31:0] i, input logic [2:0] s,
                                        input bit x64);
    logic [63:0] r;
    case (s)
      3'd0: r = {{52{i[31]}}, i[31:20]};
      3'd1: r = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: r = {{32{i[31]}}, i[31:12], 12'h000};
      3'd4: r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd5: r = {59'd0, i[19:15]};
      3'd6: r = x64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Scoreboard: every output handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && ov_a && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got tag=%0d imm=%h, expected no output", tag_a, imm_a);
      end else begin
        mon_e = sb.pop_front();
        if (imm_a !== mon_e.e32 || tag_a !== mon_e.tag || ill_a !== mon_e.ill) begin
          errors++;
          $display("FAIL out32: got imm=%h tag=%0d ill=%b, expected imm=%h tag=%0d ill=%b",
                   imm_a, tag_a, ill_a, mon_e.e32, mon_e.tag, mon_e.ill);
        end
        checks++;
        if (ov_b !== 1'b1 || imm_b !== mon_e.e64 || tag_b !== mon_e.tag || ill_b !== mon_e.ill) begin
          errors++;
          $display("FAIL out64: got v=%b imm=%h tag=%0d ill=%b, expected v=1 imm=%h tag=%0d ill=%b",
                   ov_b, imm_b, tag_b, ill_b, mon_e.e64, mon_e.tag, mon_e.ill);
        end
        checks++;
        if (ov_c !== 1'b1 || imm_c !== mon_e.e32 || tag_c !== mon_e.tag) begin
          errors++;
          $display("FAIL outc: got v=%b imm=%h tag=%0d, expected v=1 imm=%h tag=%0d",
                   ov_c, imm_c, tag_c, mon_e.e32, mon_e.tag);
        end
      end
    end
  end

  // Offer one instruction, wait for acceptance, record the expected result.
  task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [3:0] tag,
                      input logic [31:0] e32, input logic [63:0] e64, input logic ill);
    exp_t e;
    int   n = 0;
    in_valid   = 1'b1;
    in_ins     = ins;
    in_imm_src = src;
    in_tag     = tag;
    @(negedge clk);
    while (rdy_a !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rdy_a !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", rdy_a, n);
    end else begin
      e.e32 = e32; e.e64 = e64; e.tag = tag; e.ill = ill;
      sb.push_back(e);
      sent++;
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_ins     = 'x;
    in_imm_src = 'x;
  endtask

  task automatic send_model(input logic [31:0] ins, input logic [2:0] src, input logic [3:0] tag);
    logic [63:0] r32;
    logic [63:0] r64;
    r32 = model(ins, src, 1'b0);
    r64 = model(ins, src, 1'b1);
    send(ins, src, tag, r32[31:0], r64, (src == 3'd7));
  endtask

  task automatic drain_wait(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || ov_a !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d out_valid=%b, expected pending=0 out_valid=0",
               name, sb.size(), ov_a);
    end
  endtask

  task automatic check_cnt(input string name);
    checks++;
    if (cnt_a !== 16'(sent) || cnt_b !== 16'(sent) || cnt_c !== 4'(sent)) begin
      errors++;
      $display("FAIL %s_acc_cnt: got %0d/%0d/%0d, expected %0d/%0d/%0d", name,
               cnt_a, cnt_b, cnt_c, 16'(sent), 16'(sent), 4'(sent));
    end
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    sb.delete();
    sent = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_ins = 'x; in_imm_src = 'x; in_tag = 4'd0;
    #12;
    checks++;
    if (rdy_a !== 1'b1 || ov_a !== 1'b0 || imm_a !== 32'd0 || tag_a !== 4'd0 || ill_a !== 1'b0
        || ov_b !== 1'b0 || imm_b !== 64'd0 || ov_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b v=%b imm=%h tag=%0d ill=%b v64=%b imm64=%h, expected 1 0 0 0 0 0 0",
               rdy_a, ov_a, imm_a, tag_a, ill_a, ov_b, imm_b);
    end
    check_cnt("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_formats();
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd0, 4'd1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    checks++;
    if (ov_a !== 1'b1 || tag_a !== 4'd1) begin
      errors++;
      $display("FAIL latency_i: got v=%b tag=%0d, expected v=1 tag=1", ov_a, tag_a);
    end
    send(32'hFE112E23, 3'd1, 4'd2, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    checks++;
    if (ov_a !== 1'b1 || tag_a !== 4'd2) begin
      errors++;
      $display("FAIL back_to_back_s: got v=%b tag=%0d, expected v=1 tag=2", ov_a, tag_a);
    end
    drain_wait("is");
    check_cnt("is");
    send(32'hFE000CE3, 3'd2, 4'd3, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 1'b0);
    send(32'h123450B7, 3'd3, 4'd4, 32'h12345000, 64'h00000000_12345000, 1'b0);
    send(32'h0010006F, 3'd4, 4'd5, 32'h00000800, 64'h00000000_00000800, 1'b0);
    send(32'h0002D073, 3'd5, 4'd6, 32'h00000005, 64'h00000000_00000005, 1'b0);
    send(32'hFFFFFFFF, 3'd7, 4'd7, 32'h00000000, 64'h00000000_00000000, 1'b1);
    send(32'h03F01013, 3'd6, 4'd8, 32'h0000001F, 64'h00000000_0000003F, 1'b0);
    send(32'h800000B7, 3'd3, 4'd9, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
    drain_wait("formats");
    check_cnt("formats");
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ins = 32'hFFF00093; in_imm_src = 3'd0; in_tag = 4'd1;
    e.e32 = 32'hFFFFFFFF; e.e64 = 64'hFFFFFFFF_FFFFFFFF; e.tag = 4'd1; e.ill = 1'b0;
    sb.push_back(e); sent++;
    @(posedge clk); #1;
    checks++;
    if (rdy_a !== 1'b1 || ov_a !== 1'b1 || tag_a !== 4'd1) begin
      errors++;
      $display("FAIL bp_first: got rdy=%b v=%b tag=%0d, expected 1 1 1", rdy_a, ov_a, tag_a);
    end
    in_ins = 32'h0002D073; in_imm_src = 3'd5; in_tag = 4'd2;
    e.e32 = 32'd5; e.e64 = 64'd5; e.tag = 4'd2;
    sb.push_back(e); sent++;
    @(posedge clk); #1;
    checks++;
    if (rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got in_ready=%b, expected 0", rdy_a);
    end
    in_ins = 32'h123450B7; in_imm_src = 3'd3; in_tag = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rdy_a !== 1'b0 || ov_a !== 1'b1 || tag_a !== 4'd1 || imm_a !== 32'hFFFFFFFF) begin
        errors++;
        $display("FAIL bp_hold: got rdy=%b v=%b tag=%0d imm=%h, expected 0 1 1 ffffffff",
                 rdy_a, ov_a, tag_a, imm_a);
      end
    end
    e.e32 = 32'h12345000; e.e64 = 64'h12345000; e.tag = 4'd3;
    sb.push_back(e); sent++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdy_a !== 1'b1 || tag_a !== 4'd2) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b tag=%0d, expected rdy=1 tag=2", rdy_a, tag_a);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_ins = 'x; in_imm_src = 'x;
    drain_wait("bp");
    check_cnt("bp");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    logic [2:0]  src;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ins = $urandom;
      src = 3'($urandom_range(0, 7));
      send_model(ins, src, 4'(k));
      checks++;
      if (rdy_a !== 1'b1 || ov_a !== 1'b1 || tag_a !== 4'(k)) begin
        errors++;
        $display("FAIL b2b_%0d: got rdy=%b v=%b tag=%0d, expected 1 1 %0d", k, rdy_a, ov_a, tag_a, k);
      end
    end
    drain_wait("b2b");
    check_cnt("b2b");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_model(32'hFFF00093, 3'd0, 4'd5);
    send_model(32'hFE112E23, 3'd1, 4'd6);
    checks++;
    if (rdy_a !== 1'b0 || ov_a !== 1'b1) begin
      errors++;
      $display("FAIL rmid_full: got rdy=%b v=%b, expected 0 1", rdy_a, ov_a);
    end
    #2;
    rst = 1'b1;
    sb.delete();
    sent = 0;
    #1;
    checks++;
    if (ov_a !== 1'b0 || rdy_a !== 1'b1 || cnt_a !== 16'd0 || imm_a !== 32'd0 || tag_a !== 4'd0
        || ov_b !== 1'b0 || cnt_c !== 4'd0) begin
      errors++;
      $display("FAIL rmid_async: got v=%b rdy=%b cnt=%0d imm=%h tag=%0d, expected 0 1 0 0 0",
               ov_a, rdy_a, cnt_a, imm_a, tag_a);
    end
    in_valid = 1'b1; in_ins = 32'hFFF00093; in_imm_src = 3'd0; in_tag = 4'd7;
    @(posedge clk); #1;
    in_valid = 1'b0; in_ins = 'x; in_imm_src = 'x;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (ov_a !== 1'b0 || ov_b !== 1'b0) begin
      errors++;
      $display("FAIL rmid_discard: got v=%b v64=%b, expected 0 0", ov_a, ov_b);
    end
    check_cnt("rmid");
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      send_model(32'h00A00513 + 32'(k << 20), 3'd0, 4'(k));
    end
    drain_wait("wrap");
    checks++;
    if (cnt_c !== 4'd1 || cnt_a !== 16'd17) begin
      errors++;
      $display("FAIL wrap_cnt: got cnt4=%0d cnt16=%0d, expected 1 17", cnt_c, cnt_a);
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
